number_splitter: RTL and testbench

NUMBER_SPLITTER -- requirements
Module: number_splitter

---
 rtl/number_splitter_pkg.sv | 29 ++
 rtl/number_splitter_bin2bcd.sv | 54 +++++
 rtl/number_splitter.sv | 165 ++++++++++++++++
 tb/tb_number_splitter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/number_splitter_pkg.sv
// Shared types and constants for the number_splitter decimal-to-UART sequencer.
package number_splitter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      SKIP,
      LOAD,
      WAIT,
      TERM,
      FINISH
   } state_t;

   // Identifies what the byte currently in flight is, so WAIT knows where to go next
   typedef enum logic [1:0] {
      KIND_DIGIT,
      KIND_MINUS,
      KIND_TERM
   } byte_kind_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;

   // ceil(width * log10(2)) using fixed-point log10(2) = 0.30103
   function automatic int unsigned calc_digits(input int unsigned width);
      return (width * 32'd30103 + 32'd99999) / 32'd100000;
   endfunction

endpackage

// File: rtl/number_splitter_bin2bcd.sv
// Serial double-dabble converter: one input bit per cycle, start/ready handshake.
module bin2bcd
   import number_splitter_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DIGITS = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  ready,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;

   // Add-3 correction on every digit >= 5, then shift one bit from the binary into the BCD
   function automatic logic [BW+WIDTH-1:0] dabble(input logic [BW-1:0] b,
                                                  input logic [WIDTH-1:0] s);
      logic [BW-1:0] adj;
      adj = b;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      return {adj, s} << 1;
   endfunction

   // The load edge already consumes the MSB (BCD starts at zero), so WIDTH edges convert WIDTH bits
   always_ff @(posedge clk) begin
      if (reset) begin
         bcd     <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else if (start && !busy_q) begin
         {bcd, shift_q} <= dabble('0, bin);
         cnt_q          <= CW'(WIDTH - 1);
         busy_q         <= (WIDTH > 1);
      end else if (busy_q) begin
         {bcd, shift_q} <= dabble(bcd, shift_q);
         cnt_q          <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) busy_q <= 1'b0;
      end
   end

   assign ready = ~busy_q;

endmodule

// File: rtl/number_splitter.sv
// Converts a binary value to ASCII decimal and feeds it byte-wise to a UART, then FIN_CHAR.
// Optional NUMBER_SPLITTER_NEG_EN: treat valor as signed and prefix negatives with '-'.
module number_splitter
   import number_splitter_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter logic [7:0]  FIN_CHAR = 8'h0D
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] valor,
   input  logic             start,
   input  logic             tx_done,
   output logic [7:0]       dato,
   output logic             tx_start,
   output logic             busy,
   output logic             done
);

   localparam int unsigned DIGITS = calc_digits(WIDTH);
   localparam int unsigned BW     = 4 * DIGITS;
   localparam int unsigned IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t           state_q, state_d;
   byte_kind_t       kind_q, kind_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [7:0]       dato_d;
   logic             tx_start_d, busy_d, done_d;
   logic             conv_start_c, conv_ready;
   logic [BW-1:0]    bcd;
   logic [WIDTH-1:0] mag_c;

   function automatic logic [7:0] digit_ascii(input logic [BW-1:0] b, input logic [IW-1:0] i);
      return ASCII_ZERO + 8'(b[4*32'(i) +: 4]);
   endfunction

`ifdef NUMBER_SPLITTER_NEG_EN
   logic neg_q, neg_d;
   // Two's-complement magnitude; the most negative value maps onto itself, which is correct unsigned
   assign mag_c = valor[WIDTH-1] ? WIDTH'(~valor + WIDTH'(1)) : valor;
`else
   assign mag_c = valor;
`endif

   bin2bcd #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start_c),
      .bin   (mag_c),
      .ready (conv_ready),
      .bcd   (bcd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         kind_q   <= KIND_DIGIT;
         idx_q    <= '0;
         dato     <= 8'h00;
         tx_start <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef NUMBER_SPLITTER_NEG_EN
         neg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         idx_q    <= idx_d;
         dato     <= dato_d;
         tx_start <= tx_start_d;
         busy     <= busy_d;
         done     <= done_d;
`ifdef NUMBER_SPLITTER_NEG_EN
         neg_q    <= neg_d;
`endif
      end
   end

   // Outputs are computed for the state being entered, so tx_start is high during LOAD/TERM
   always_comb begin
      state_d      = state_q;
      kind_d       = kind_q;
      idx_d        = idx_q;
      dato_d       = dato;
      tx_start_d   = 1'b0;
      busy_d       = busy;
      done_d       = 1'b0;
      conv_start_c = 1'b0;
`ifdef NUMBER_SPLITTER_NEG_EN
      neg_d        = neg_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               conv_start_c = 1'b1;
               busy_d       = 1'b1;
               idx_d        = IW'(DIGITS - 1);
               state_d      = CONVERT;
`ifdef NUMBER_SPLITTER_NEG_EN
               neg_d        = valor[WIDTH-1];
`endif
            end
         end
         CONVERT: begin
            if (conv_ready) state_d = SKIP;
         end
         SKIP: begin
            if (digit_ascii(bcd, idx_q) != ASCII_ZERO || idx_q == '0) begin
               state_d    = LOAD;
               tx_start_d = 1'b1;
               dato_d     = digit_ascii(bcd, idx_q);
               kind_d     = KIND_DIGIT;
`ifdef NUMBER_SPLITTER_NEG_EN
               if (neg_q) begin
                  dato_d = ASCII_MINUS;
                  kind_d = KIND_MINUS;
                  neg_d  = 1'b0;
               end
`endif
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         LOAD: state_d = WAIT;
         TERM: state_d = WAIT;
         WAIT: begin
            if (tx_done) begin
               case (kind_q)
                  KIND_TERM: begin
                     state_d = FINISH;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                  end
                  KIND_MINUS: begin
                     state_d    = LOAD;
                     tx_start_d = 1'b1;
                     dato_d     = digit_ascii(bcd, idx_q);
                     kind_d     = KIND_DIGIT;
                  end
                  default: begin
                     tx_start_d = 1'b1;
                     if (idx_q == '0) begin
                        state_d = TERM;
                        dato_d  = FIN_CHAR;
                        kind_d  = KIND_TERM;
                     end else begin
                        state_d = LOAD;
                        idx_d   = idx_q - IW'(1);
                        dato_d  = digit_ascii(bcd, idx_q - IW'(1));
                     end
                  end
               endcase
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_number_splitter.sv
// Scoreboard bench for number_splitter: model pushes expected bytes, monitor pops on tx_start.
module tb_number_splitter;
   import number_splitter_pkg::*;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned DIGITS = calc_digits(WIDTH);
   localparam logic [7:0]  FIN    = 8'h0D;

   logic             clk = 1'b0;
   logic             reset, start, tx_done;
   logic [WIDTH-1:0] valor;
   logic [7:0]       dato;
   logic             tx_start, busy, done;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] q_exp[$];
   int         done_exp = 0;
   int         cyc = 0;
   int         txs_cnt = 0;
   int         start_cyc = 0;
   bit         first_pend = 1'b0;
   bit         spur_req = 1'b0;
   bit         fixed_delay = 1'b1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   number_splitter #(.WIDTH(WIDTH), .FIN_CHAR(FIN)) dut (
      .clk      (clk),
      .reset    (reset),
      .valor    (valor),
      .start    (start),
      .tx_done  (tx_done),
      .dato     (dato),
      .tx_start (tx_start),
      .busy     (busy),
      .done     (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: decimal string of the value by plain division, sign first, then terminator
   task automatic push_expected(input logic [31:0] v);
      longint unsigned mag;
      logic [7:0]      digs[$];
      mag = {32'b0, v};
`ifdef NUMBER_SPLITTER_NEG_EN
      if (v[31]) begin
         q_exp.push_back(8'h2D);
         mag = 64'h1_0000_0000 - {32'b0, v};
      end
`endif
      do begin
         digs.push_front(8'h30 + 8'(mag % 10));
         mag = mag / 10;
      end while (mag != 0);
      foreach (digs[i]) q_exp.push_back(digs[i]);
      q_exp.push_back(FIN);
   endtask

   // Monitor: pops and compares each presented byte; checks pulse shape, stability, handshakes
   initial begin : monitor
      bit         in_flight, stable, pend_next, prev_ts;
      logic [7:0] cur, e;
      in_flight = 0; stable = 0; pend_next = 0; prev_ts = 0; cur = 0;
      forever begin
         @(negedge clk);
         if (pend_next) begin
            pend_next = 0;
            if (q_exp.size() > 0) check("tx_start_one_cycle_after_tx_done", 32'(tx_start), 1);
            else                  check("done_one_cycle_after_term", 32'(done), 1);
         end
         if (tx_start) begin
            check("tx_start_single_cycle", 32'(prev_ts), 0);
            if (first_pend) begin
               first_pend = 0;
               check("first_tx_latency_bound",
                     32'((cyc - start_cyc - 1) <= int'(WIDTH + DIGITS + 2)), 1);
            end
            if (q_exp.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got %0h, required no byte (cycle %0d)", dato, cyc);
            end else begin
               e = q_exp.pop_front();
               check("byte", 32'(dato), 32'(e));
            end
            cur = dato; stable = 1; in_flight = 1;
            txs_cnt++;
         end else if (in_flight) begin
            if (dato !== cur) stable = 0;
            if (tx_done) begin
               check("dato_stable_until_tx_done", 32'(stable), 1);
               in_flight = 0;
               pend_next = 1;
            end
         end
         if (done) begin
            check("done_at_end_of_message",
                  32'(q_exp.size() == 0 && done_exp > 0 && !busy), 1);
            if (done_exp > 0) done_exp--;
         end
         prev_ts = tx_start;
         if (reset) begin
            in_flight = 0;
            pend_next = 0;
         end
      end
   end

   // UART model: answers each tx_start with a tx_done; sometimes adds a same-cycle pulse to be ignored
   initial begin : responder
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start && !reset) begin
            int d;
            bit early;
            d     = fixed_delay ? 10 : int'($urandom_range(1, 12));
            early = !fixed_delay && ($urandom_range(0, 3) == 0);
            if (early) tx_done = 1'b1;
            @(posedge clk); #1;
            tx_done = 1'b0;
            repeat (d - 1) begin @(posedge clk); #1; end
            tx_done = 1'b1;
            @(posedge clk); #1;
            tx_done = 1'b0;
         end else if (spur_req) begin
            @(posedge clk); #1;
            tx_done = 1'b1;
            @(posedge clk); #1;
            tx_done = 1'b0;
            spur_req = 1'b0;
         end
      end
   end

   task automatic send(input logic [31:0] v);
      push_expected(v);
      done_exp++;
      valor      = v;
      start      = 1'b1;
      start_cyc  = cyc;
      first_pend = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      valor = $urandom;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_exp > 0 && n < 3000) begin @(posedge clk); #1; n++; end
      check("transfer_completes", 32'(done_exp == 0), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dato"},     32'(dato),     0);
      check({tag, "_tx_start"}, 32'(tx_start), 0);
      check({tag, "_busy"},     32'(busy),     0);
      check({tag, "_done"},     32'(done),     0);
   endtask

   initial begin : stimulus
      int base, n;
      logic [31:0] v;
      reset = 1'b1; start = 1'b0; valor = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");

      // Reset wins over a simultaneous start
      start = 1'b1; valor = 32'd5;
      @(posedge clk); #1;
      check("reset_beats_start_busy", 32'(busy), 0);
      start = 1'b0; reset = 1'b0;
      @(posedge clk); #1;

      // Spurious tx_done in IDLE
      spur_req = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      check("spurious_tx_done_busy", 32'(busy), 0);
      check("spurious_tx_done_dato", 32'(dato), 0);

      send(32'd0);
      wait_done();

      // Start while busy must be ignored
      send(32'd1234);
      repeat (60) begin @(posedge clk); #1; end
      check("busy_during_send", 32'(busy), 1);
      valor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();

`ifdef NUMBER_SPLITTER_NEG_EN
      send(32'hFFFF_FFD3);
      wait_done();
      send(32'h8000_0000);
      wait_done();
`else
      send(32'hFFFF_FFFF);
      wait_done();
`endif

      // Reset after the second byte of 1234 aborts the transfer
      base = txs_cnt;
      send(32'd1234);
      n = 0;
      while (txs_cnt < base + 2 && n < 1000) begin @(posedge clk); #1; n++; end
      check("second_tx_start_seen", 32'(txs_cnt >= base + 2), 1);
      reset = 1'b1;
      q_exp.delete();
      done_exp   = 0;
      first_pend = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("midsend_reset");
      reset = 1'b0;
      repeat (40) begin @(posedge clk); #1; end
      check("no_activity_after_abort", 32'(busy), 0);
      send(32'd9);
      wait_done();

      // Randomised values and UART response delays
      fixed_delay = 1'b0;
      for (int i = 0; i < 20; i++) begin
         v = (i % 3 == 0) ? 32'($urandom_range(0, 999)) : $urandom;
         send(v);
         wait_done();
      end

      check("scoreboard_empty", 32'(q_exp.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
